// File: rtl/sme_pkg.sv
// sme_pkg: shared types and constants for the SME host feeder.
// Holds the feeder state enum, the default buffer depths and the
// special characters understood by the string-matching engine.
package sme_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND_S = 3'd1,
    ST_SEND_P = 3'd2,
    ST_WAIT   = 3'd3,
    ST_REPORT = 3'd4
  } sme_state_e;

  localparam int STR_MAX_DEF = 32;
  localparam int PAT_MAX_DEF = 8;

  localparam logic [7:0] CHAR_CARET  = 8'h5E;
  localparam logic [7:0] CHAR_DOLLAR = 8'h24;
  localparam logic [7:0] CHAR_DOT    = 8'h2E;
  localparam logic [7:0] CHAR_STAR   = 8'h2A;
  localparam logic [7:0] CHAR_SPACE  = 8'h20;

endpackage

// File: rtl/sme_char_buf.sv
// sme_char_buf: small 8-bit character register file with a write
// pointer equal to the current length. The length saturates at DEPTH
// and extra writes are dropped. A job start arms a fresh flag so that
// the next write begins a new buffer at index 0 instead of appending.
module sme_char_buf #(
  parameter int DEPTH = 32,
  parameter int LW    = $clog2(DEPTH + 1),
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          arm,
  input  logic [AW-1:0] rd_idx,
  output logic [7:0]    rd_data,
  output logic [LW-1:0] len
);

  logic [7:0] mem [DEPTH];
  logic       fresh;
  logic       room;

  assign room    = (len < LW'(DEPTH));
  assign rd_data = mem[rd_idx];

  // Length and fresh-flag bookkeeping; a fresh write restarts at length 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len   <= '0;
      fresh <= 1'b0;
    end else begin
      if (wr_en) begin
        if (fresh) begin
          len <= LW'(1);
        end else if (room) begin
          len <= len + LW'(1);
        end
      end
      if (arm) begin
        fresh <= 1'b1;
      end else if (wr_en) begin
        fresh <= 1'b0;
      end
    end
  end

  // Character storage; contents are only meaningful below len, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (fresh) begin
        mem[0] <= wr_data;
      end else if (room) begin
        mem[len[AW-1:0]] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/sme_feeder.sv
// sme_feeder: host-side driver for the SME character interface.
// Buffers a string and a pattern written by the host, streams them to
// the SME, waits for its result and hands it back over valid/ready.
// Optional WAIT timeout is built when SME_FEEDER_TIMEOUT_EN is defined.
module sme_feeder
  import sme_pkg::*;
#(
  parameter int STR_MAX = STR_MAX_DEF,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic       keep_str,
  output logic       busy,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_err,
  output logic       res_timeout
);

  localparam int SLW = $clog2(STR_MAX + 1);
  localparam int PLW = $clog2(PAT_MAX + 1);
  localparam int SAW = $clog2(STR_MAX);
  localparam int PAW = $clog2(PAT_MAX);

  sme_state_e     state, state_n;
  logic [SAW-1:0] idx, idx_n;
  logic           str_sent, str_sent_n;
  logic           arm;
  logic           wr_ok;
  logic           job_err;
  logic           timeout_hit;

  logic [SLW-1:0] str_len;
  logic [PLW-1:0] pat_len;
  logic [7:0]     str_rd, pat_rd;

  logic [7:0]     chardata_n;
  logic           isstring_n, ispattern_n, busy_n;
  logic           res_valid_n, res_match_n, res_err_n, res_timeout_n;
  logic [4:0]     res_index_n;

  assign wr_ok   = wr_en && (state == ST_IDLE);
  assign job_err = (pat_len == '0) ||
                   (!keep_str && (str_len == '0)) ||
                   (keep_str && !str_sent);

  sme_char_buf #(.DEPTH(STR_MAX)) u_str_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok && !wr_sel),
    .wr_data (wr_data),
    .arm     (arm),
    .rd_idx  (idx_n),
    .rd_data (str_rd),
    .len     (str_len)
  );

  sme_char_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok && wr_sel),
    .wr_data (wr_data),
    .arm     (arm),
    .rd_idx  (idx_n[PAW-1:0]),
    .rd_data (pat_rd),
    .len     (pat_len)
  );

`ifdef SME_FEEDER_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign timeout_hit = (state == ST_WAIT) && ((wait_cnt + 8'd1) == 8'(TIMEOUT));

  // WAIT cycle counter, restarted every time WAIT is entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= 8'd0;
    end else if (state != ST_WAIT) begin
      wait_cnt <= 8'd0;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state, stream index and next registered output values.
  always_comb begin
    state_n       = state;
    idx_n         = idx;
    str_sent_n    = str_sent;
    arm           = 1'b0;
    isstring_n    = 1'b0;
    ispattern_n   = 1'b0;
    res_valid_n   = res_valid;
    res_match_n   = res_match;
    res_index_n   = res_index;
    res_err_n     = res_err;
    res_timeout_n = res_timeout;
    case (state)
      ST_IDLE: begin
        if (start) begin
          arm   = 1'b1;
          idx_n = '0;
          if (job_err) begin
            state_n       = ST_REPORT;
            res_valid_n   = 1'b1;
            res_err_n     = 1'b1;
            res_match_n   = 1'b0;
            res_index_n   = 5'd0;
            res_timeout_n = 1'b0;
          end else if (keep_str) begin
            state_n     = ST_SEND_P;
            ispattern_n = 1'b1;
          end else begin
            state_n    = ST_SEND_S;
            isstring_n = 1'b1;
            str_sent_n = 1'b1;
          end
        end
      end
      ST_SEND_S: begin
        if ((SLW'(idx) + SLW'(1)) < str_len) begin
          idx_n      = idx + SAW'(1);
          isstring_n = 1'b1;
        end else begin
          state_n     = ST_SEND_P;
          idx_n       = '0;
          ispattern_n = 1'b1;
        end
      end
      ST_SEND_P: begin
        if ((PLW'(idx) + PLW'(1)) < pat_len) begin
          idx_n       = idx + SAW'(1);
          ispattern_n = 1'b1;
        end else begin
          state_n = ST_WAIT;
          idx_n   = '0;
        end
      end
      ST_WAIT: begin
        if (valid) begin
          state_n       = ST_REPORT;
          res_valid_n   = 1'b1;
          res_match_n   = match;
          res_index_n   = match_index;
          res_err_n     = 1'b0;
          res_timeout_n = 1'b0;
        end else if (timeout_hit) begin
          state_n       = ST_REPORT;
          res_valid_n   = 1'b1;
          res_match_n   = 1'b0;
          res_index_n   = 5'd0;
          res_err_n     = 1'b0;
          res_timeout_n = 1'b1;
        end
      end
      ST_REPORT: begin
        if (res_ready) begin
          state_n     = ST_IDLE;
          res_valid_n = 1'b0;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  // Character mux for the next cycle, fed by the buffers at the next index.
  always_comb begin
    chardata_n = 8'h00;
    if (isstring_n) begin
      chardata_n = str_rd;
    end else if (ispattern_n) begin
      chardata_n = pat_rd;
    end
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      str_sent    <= 1'b0;
      busy        <= 1'b0;
      chardata    <= 8'h00;
      isstring    <= 1'b0;
      ispattern   <= 1'b0;
      res_valid   <= 1'b0;
      res_match   <= 1'b0;
      res_index   <= 5'd0;
      res_err     <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      str_sent    <= str_sent_n;
      busy        <= busy_n;
      chardata    <= chardata_n;
      isstring    <= isstring_n;
      ispattern   <= ispattern_n;
      res_valid   <= res_valid_n;
      res_match   <= res_match_n;
      res_index   <= res_index_n;
      res_err     <= res_err_n;
      res_timeout <= res_timeout_n;
    end
  end

endmodule

// File: tb/tb_sme_feeder.sv
// tb_sme_feeder: directed bench for sme_feeder with hand-computed
// expectations. Inputs change on the falling edge, outputs are
// checked on the falling edge after the rising edge that produced them.
module tb_sme_feeder;
  import sme_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic       wr_sel = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       start = 1'b0;
  logic       keep_str = 1'b0;
  logic       busy;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       valid = 1'b0;
  logic       match = 1'b0;
  logic [4:0] match_index = 5'd0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic       res_match;
  logic [4:0] res_index;
  logic       res_err;
  logic       res_timeout;

  int vec_count  = 0;
  int miss_count = 0;

  sme_feeder #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_data     (wr_data),
    .start       (start),
    .keep_str    (keep_str),
    .busy        (busy),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .valid       (valid),
    .match       (match),
    .match_index (match_index),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_match   (res_match),
    .res_index   (res_index),
    .res_err     (res_err),
    .res_timeout (res_timeout)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic sel, input logic [7:0] ch);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_data = ch;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic write_str(input logic sel, input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(sel, s[i]);
  endtask

  task automatic launch(input logic keep);
    start    = 1'b1;
    keep_str = keep;
    step();
    start    = 1'b0;
    keep_str = 1'b0;
  endtask

  task automatic respond(input logic m, input logic [4:0] ix);
    valid       = 1'b1;
    match       = m;
    match_index = ix;
    step();
    valid       = 1'b0;
    match       = 1'b0;
    match_index = 5'd0;
  endtask

  task automatic accept();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  // Hard stop in case the stimulus itself wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] exp_s [5];
    int         cnt_s, cnt_p, cnt_both;
    exp_s = '{8'h61, 8'h62, CHAR_SPACE, 8'h63, 8'h64};

    // Reset state
    repeat (3) step();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_chardata", chardata, 0);
    checkOutput("rst_isstring", isstring, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res_err", res_err, 0);
    reset = 1'b1;
    step();

    // Job 1: string "ab cd", pattern "cd"
    write_str(1'b0, "ab cd");
    write_str(1'b1, "cd");
    launch(1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("j1_isstring%0d", i), isstring, 1);
      checkOutput($sformatf("j1_ispat_lo%0d", i), ispattern, 0);
      checkOutput($sformatf("j1_str_char%0d", i), chardata, exp_s[i]);
      step();
    end
    checkOutput("j1_pat0_flag", ispattern, 1);
    checkOutput("j1_pat0_str_lo", isstring, 0);
    checkOutput("j1_pat0_char", chardata, 8'h63);
    step();
    checkOutput("j1_pat1_flag", ispattern, 1);
    checkOutput("j1_pat1_char", chardata, 8'h64);
    step();
    checkOutput("j1_wait_isstring", isstring, 0);
    checkOutput("j1_wait_ispattern", ispattern, 0);
    checkOutput("j1_wait_chardata", chardata, 0);
    checkOutput("j1_wait_busy", busy, 1);
    checkOutput("j1_wait_res_valid", res_valid, 0);
    respond(1'b1, 5'd3);
    checkOutput("j1_res_valid", res_valid, 1);
    checkOutput("j1_res_match", res_match, 1);
    checkOutput("j1_res_index", res_index, 3);
    checkOutput("j1_res_err", res_err, 0);
    repeat (3) step();
    checkOutput("j1_hold_valid", res_valid, 1);
    checkOutput("j1_hold_index", res_index, 3);
    accept();
    checkOutput("j1_done_valid", res_valid, 0);
    checkOutput("j1_done_busy", busy, 0);

    // valid while IDLE is ignored
    respond(1'b1, 5'd7);
    checkOutput("idle_valid_ignored", res_valid, 0);

    // Job 2: keep string, new pattern "^a"
    applyStimulus(1'b1, CHAR_CARET);
    applyStimulus(1'b1, 8'h61);
    launch(1'b1);
    checkOutput("j2_p0_isstring", isstring, 0);
    checkOutput("j2_p0_ispattern", ispattern, 1);
    checkOutput("j2_p0_char", chardata, CHAR_CARET);
    step();
    checkOutput("j2_p1_ispattern", ispattern, 1);
    checkOutput("j2_p1_char", chardata, 8'h61);
    step();
    checkOutput("j2_wait_ispattern", ispattern, 0);
    respond(1'b0, 5'd0);
    checkOutput("j2_res_valid", res_valid, 1);
    checkOutput("j2_res_match", res_match, 0);
    accept();

    // Job 3: 33 writes of 'x' saturate at 32 string characters
    for (int i = 0; i < 33; i++) applyStimulus(1'b0, 8'h78);
    applyStimulus(1'b1, 8'h78);
    launch(1'b0);
    cnt_s = 0; cnt_p = 0; cnt_both = 0;
    for (int i = 0; i < 40; i++) begin
      if (isstring) cnt_s++;
      if (ispattern) cnt_p++;
      if (isstring && ispattern) cnt_both++;
      step();
    end
    checkOutput("j3_isstring_cycles", cnt_s, 32);
    checkOutput("j3_ispattern_cycles", cnt_p, 1);
    checkOutput("j3_overlap_cycles", cnt_both, 0);
    respond(1'b1, 5'd31);
    checkOutput("j3_res_index", res_index, 31);
    accept();

    // Job 4: SME never answers
    launch(1'b1);
    checkOutput("j4_ispattern", ispattern, 1);
    step();
`ifdef SME_FEEDER_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("j4_wait_valid%0d", i), res_valid, 0);
      step();
    end
    checkOutput("j4_to_valid", res_valid, 1);
    checkOutput("j4_to_flag", res_timeout, 1);
    checkOutput("j4_to_match", res_match, 0);
    checkOutput("j4_to_index", res_index, 0);
`else
    repeat (300) step();
    checkOutput("j4_busy_hold", busy, 1);
    checkOutput("j4_no_res", res_valid, 0);
    respond(1'b1, 5'd2);
    checkOutput("j4_res_valid", res_valid, 1);
    checkOutput("j4_res_timeout", res_timeout, 0);
`endif
    accept();

    // Job 5: reset asserted on the 3rd string character
    write_str(1'b0, "abcde");
    applyStimulus(1'b1, 8'h78);
    launch(1'b0);
    checkOutput("j5_c0", chardata, 8'h61);
    step();
    step();
    checkOutput("j5_c2_flag", isstring, 1);
    checkOutput("j5_c2_char", chardata, 8'h63);
    reset = 1'b0;
    #1;
    checkOutput("j5_rst_isstring", isstring, 0);
    checkOutput("j5_rst_chardata", chardata, 0);
    checkOutput("j5_rst_busy", busy, 0);
    step();
    reset = 1'b1;
    step();
    launch(1'b0);
    checkOutput("j5_err_valid", res_valid, 1);
    checkOutput("j5_err_flag", res_err, 1);
    checkOutput("j5_err_isstring", isstring, 0);
    checkOutput("j5_err_ispattern", ispattern, 0);
    checkOutput("j5_err_busy", busy, 1);
    step();
    checkOutput("j5_err_quiet", isstring | ispattern, 0);
    accept();
    checkOutput("j5_err_done_busy", busy, 0);

    // Job 6: string present but pattern empty
    write_str(1'b0, "ab");
    launch(1'b0);
    checkOutput("j6_err_flag", res_err, 1);
    checkOutput("j6_err_isstring", isstring, 0);
    accept();

    // Job 7: keep_str with no string sent since reset
    applyStimulus(1'b1, 8'h78);
    launch(1'b1);
    checkOutput("j7_err_flag", res_err, 1);
    checkOutput("j7_err_ispattern", ispattern, 0);
    accept();

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/sme_feeder.md
# sme_feeder

Host-side driver for the string-matching engine (SME) character interface. It buffers one string of up to 32 characters and one pattern of up to 8 characters written by a host, then streams them to the SME on `chardata`/`isstring`/`ispattern`. It waits for the SME's `valid`, captures `match`/`match_index`, and returns the result to the host through a valid/ready handshake. It sits between the host write port and one SME instance; both share clock and reset.

## Interface
- `STR_MAX`, default 32: string buffer depth; length field is 6 bits.
- `PAT_MAX`, default 8: pattern buffer depth; length field is 4 bits.
- `TIMEOUT`, default 255: maximum WAIT cycles, used only with the timeout feature.

- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `wr_en` in 1: host character write strobe.
- `wr_sel` in 1: target buffer; 0 = string, 1 = pattern.
- `wr_data` in 8: character to write.
- `start` in 1: launch job; accepted only in IDLE.
- `keep_str` in 1: sampled with `start`; skip the string phase and reuse the string the SME already holds.
- `busy` out 1: high from the cycle after an accepted `start` until the report is accepted.
- `chardata` out 8: character to the SME.
- `isstring` out 1: marks a string character.
- `ispattern` out 1: marks a pattern character.
- `valid` in 1: result strobe from the SME.
- `match` in 1: match flag from the SME.
- `match_index` in 5: match position from the SME.
- `res_valid` out 1: result available to the host.
- `res_ready` in 1: host accepts the result.
- `res_match` out 1: captured match flag.
- `res_index` out 5: captured match index.
- `res_err` out 1: job rejected; no SME traffic was sent.
- `res_timeout` out 1: SME did not respond in time.

## Operation
- States: IDLE, SEND_S, SEND_P, WAIT, REPORT.
- **Buffer writes**
  - Writes are accepted only in IDLE and ignored otherwise.
  - Each write stores at the buffer's length index, then increments that length.
  - Lengths saturate at `STR_MAX`/`PAT_MAX`; writes beyond saturation are dropped.
  - A job start sets a fresh flag per buffer. The next write to a buffer with its flag set restarts that buffer at index 0 and clears the flag.
  - The string buffer is therefore retained across jobs until it is rewritten.
- **IDLE + `start`** selects one of:
  - If `pat_len`==0, or (`keep_str`=0 and `str_len`==0), or (`keep_str`=1 and no string has been sent since reset): go to REPORT with `res_err`=1, `res_match`=0, `res_index`=0.
  - Else if `keep_str`=1: go to SEND_P.
  - Else: go to SEND_S.
- **SEND_S**
  - Drives `isstring`=1 with `chardata`=string[i] for i = 0..`str_len`-1, one character per cycle.
  - Goes to SEND_P with no gap.
- **SEND_P**
  - Drives `ispattern`=1 with `chardata`=pattern[j] for j = 0..`pat_len`-1.
  - Then goes to WAIT.
- **WAIT**
  - `isstring`=`ispattern`=0 and `chardata`=0.
  - On `valid`=1: capture `match`/`match_index` into `res_match`/`res_index` and go to REPORT.
- **REPORT**
  - `res_valid`=1; all `res_*` fields are held stable.
  - When `res_valid`&&`res_ready`: go to IDLE, clear `res_valid`, drop `busy`.
- `valid` outside WAIT is ignored.
- `res_ready` without `res_valid` has no effect.
- `start` outside IDLE is ignored.
- `isstring` and `ispattern` are never high in the same cycle.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Reset assertion takes effect immediately, including mid-stream. It clears the state, both lengths, the fresh flags and the string-sent flag.
- `start` sampled at edge N:
  - first character is on `chardata` in cycle N+1;
  - stream lasts `str_len`+`pat_len` cycles (`pat_len` only with `keep_str`);
  - WAIT begins in the cycle after the last character.
- `valid` sampled at edge M gives `res_valid`=1 in cycle M+1.
- `res_valid`&&`res_ready` at edge K: IDLE and `busy`=0 in cycle K+1. `start` is accepted again at edge K+1 at the earliest.
- Error path: `start` at N gives `res_valid`=`res_err`=1 in cycle N+1.

## Configuration
- Macro `SME_FEEDER_TIMEOUT_EN`.
- Defined:
  - an 8-bit WAIT counter clears on WAIT entry and increments each WAIT cycle;
  - when it reaches `TIMEOUT` without `valid`, go to REPORT with `res_timeout`=1, `res_match`=0, `res_index`=0;
  - if `valid` and the timeout occur in the same cycle, `valid` wins.
- Not defined:
  - no counter is built;
  - WAIT lasts indefinitely;
  - `res_timeout` is tied to 0.

## Structure
- Package `sme_pkg` holds:
  - the state enum;
  - `STR_MAX`/`PAT_MAX` defaults;
  - SME character constants: `^`=8'h5E, `$`=8'h24, `.`=8'h2E, `*`=8'h2A, space=8'h20.
- Sub-module `sme_char_buf`: parameterised-depth 8-bit register file with write pointer, saturating length, fresh-flag restart and asynchronous read port. It is instantiated twice, once for the string and once for the pattern.

## Test plan
- Write string "ab cd" and pattern "cd", then `start` → `isstring` for 5 cycles ('a','b',8'h20,'c','d'), then `ispattern` for 2 cycles, then both 0. Model `valid` with match=1, index=3 → `res_valid`=1, `res_match`=1, `res_index`=3, held until `res_ready`.
- After the job above, write pattern "^a" and `start` with `keep_str`=1 → zero `isstring` cycles, `ispattern` for 2 cycles (8'h5E, 'a'). Model match=0 → `res_match`=0.
- `start` with `pat_len`=0 → `res_err`=1 in cycle N+1; `isstring`/`ispattern` never assert.
- 33 string writes of 'x' → `str_len`=32; exactly 32 `isstring` cycles.
- `SME_FEEDER_TIMEOUT_EN` with `TIMEOUT`=16 and no `valid` → `res_timeout`=1 after 16 WAIT cycles. Without the macro, `busy` stays 1 for at least 300 cycles.
- Assert reset (0) in SEND_S at the 3rd character → `isstring`=0 immediately. After release the block is in IDLE with lengths 0, and `start` gives `res_err`=1.
